// File: rtl/byte_reg_bank_pkg.sv
// Shared definitions for byte_reg_bank: byte width, address-width helper and
// the byte-masked merge used by every register word.
`timescale 1ns/1ps
package byte_reg_bank_pkg;

    localparam int BYTE_W    = 8;
    // Widest word the merge helper handles; callers zero-extend and truncate.
    localparam int MAX_BYTES = 32;
    localparam int MAX_W     = MAX_BYTES * BYTE_W;

    // clog2 that never returns less than 1, so a single-register bank still
    // has a 1-bit address port.
    function automatic int clog2_min1(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Bytes with be[i]=1 come from new_w, the rest keep old_w.
    function automatic logic [MAX_W-1:0] byte_merge(input logic [MAX_W-1:0]     old_w,
                                                    input logic [MAX_W-1:0]     new_w,
                                                    input logic [MAX_BYTES-1:0] be);
        logic [MAX_W-1:0] res;
        res = old_w;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (be[i]) res[i*BYTE_W +: BYTE_W] = new_w[i*BYTE_W +: BYTE_W];
        end
        return res;
    endfunction

endpackage

// File: rtl/byte_reg_bank_word.sv
// One double-buffered register: shadow word (written), active word (read),
// and a dirty flag marking uncommitted shadow bytes.
`timescale 1ns/1ps
module byte_reg_word
    import byte_reg_bank_pkg::*;
#(
    parameter int                          DATA_BYTES = 2,
    parameter logic [DATA_BYTES*8-1:0]     RESET_VAL  = '0
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      we,
    input  logic [DATA_BYTES-1:0]     be,
    input  logic [DATA_BYTES*8-1:0]   d,
    input  logic                      commit,
    output logic [DATA_BYTES*8-1:0]   active,
    output logic                      dirty
);

    localparam int DW = DATA_BYTES * BYTE_W;

    logic [DW-1:0] r_shadow;
    logic [DW-1:0] r_active;
    logic          r_dirty;
    logic          w_wr_eff;

    // An all-zero byte enable writes nothing, so it must not mark the word dirty.
    assign w_wr_eff = we && (be != '0);

    // Commit copies the pre-edge shadow; a same-cycle write stays staged and
    // keeps the word dirty across the commit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_shadow <= RESET_VAL;
            r_active <= RESET_VAL;
            r_dirty  <= 1'b0;
        end else begin
            if (commit) r_active <= r_shadow;
            if (w_wr_eff) begin
                r_shadow <= DW'(byte_merge(MAX_W'(r_shadow), MAX_W'(d), MAX_BYTES'(be)));
            end
            if (commit)        r_dirty <= w_wr_eff;
            else if (w_wr_eff) r_dirty <= 1'b1;
        end
    end

    assign active = r_active;
    assign dirty  = r_dirty;

endmodule

// File: rtl/byte_reg_bank.sv
// byte_reg_bank: NUM_REGS double-buffered byte-enabled registers with atomic
// commit and 1-cycle registered read of the active copy.
// Optional macro BYTE_PARITY_EN adds rd_par, per-byte even parity of rd_data.
`timescale 1ns/1ps
module byte_reg_bank
    import byte_reg_bank_pkg::*;
#(
    parameter int                          DATA_BYTES = 2,
    parameter int                          NUM_REGS   = 4,
    parameter logic [DATA_BYTES*8-1:0]     RESET_VAL  = '0
) (
    input  logic                                          clk,
    input  logic                                          resetn,
    input  logic                                          wr_en,
    input  logic [byte_reg_bank_pkg::clog2_min1(NUM_REGS)-1:0] wr_addr,
    input  logic [DATA_BYTES-1:0]                         byteena,
    input  logic [DATA_BYTES*8-1:0]                       D,
    input  logic                                          commit,
    input  logic [byte_reg_bank_pkg::clog2_min1(NUM_REGS)-1:0] rd_addr,
    output logic [DATA_BYTES*8-1:0]                       rd_data,
    output logic [NUM_REGS-1:0]                           dirty,
    output logic                                          pending
`ifdef BYTE_PARITY_EN
    ,
    output logic [DATA_BYTES-1:0]                         rd_par
`endif
);

    localparam int AW = clog2_min1(NUM_REGS);
    localparam int DW = DATA_BYTES * BYTE_W;

    logic [DW-1:0] w_active [NUM_REGS];
    logic [DW-1:0] w_rd_word;
    logic [DW-1:0] r_rd_data;

    // Per-register write decode; addresses >= NUM_REGS match nothing.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_word
        logic w_we;
        assign w_we = wr_en && (wr_addr == AW'(g));

        byte_reg_word #(
            .DATA_BYTES (DATA_BYTES),
            .RESET_VAL  (RESET_VAL)
        ) u_word (
            .clk    (clk),
            .resetn (resetn),
            .we     (w_we),
            .be     (byteena),
            .d      (D),
            .commit (commit),
            .active (w_active[g]),
            .dirty  (dirty[g])
        );
    end

    // Read mux over active words; out-of-range addresses read as zero.
    always_comb begin
        w_rd_word = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (rd_addr == AW'(r)) w_rd_word = w_active[r];
        end
    end

    // Registered read data, sampling active contents before the edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_rd_data <= '0;
        else         r_rd_data <= w_rd_word;
    end

    assign rd_data = r_rd_data;
    assign pending = |dirty;

`ifdef BYTE_PARITY_EN
    logic [DATA_BYTES-1:0] w_rd_par;
    logic [DATA_BYTES-1:0] r_rd_par;

    // Parity of the word being loaded, so rd_par lines up with rd_data.
    always_comb begin
        w_rd_par = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            w_rd_par[i] = ^w_rd_word[i*BYTE_W +: BYTE_W];
        end
    end

    // Parity flop, same timing and reset as rd_data.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_rd_par <= '0;
        else         r_rd_par <= w_rd_par;
    end

    assign rd_par = r_rd_par;
`endif

endmodule

// File: tb/tb_byte_reg_bank.sv
// Scoreboard bench for byte_reg_bank (DATA_BYTES=2, NUM_REGS=4).
`timescale 1ns/1ps
module tb_byte_reg_bank;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_addr = '0;
    logic [1:0]  byteena = '0;
    logic [15:0] D = '0;
    logic        commit = 1'b0;
    logic [1:0]  rd_addr = '0;
    logic [15:0] rd_data;
    logic [3:0]  dirty;
    logic        pending;
`ifdef BYTE_PARITY_EN
    logic [1:0]  rd_par;
`endif

    byte_reg_bank #(.DATA_BYTES(2), .NUM_REGS(4), .RESET_VAL(16'h0000)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .byteena (byteena),
        .D       (D),
        .commit  (commit),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .dirty   (dirty),
        .pending (pending)
`ifdef BYTE_PARITY_EN
        ,
        .rd_par  (rd_par)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] rd;
        logic [3:0]  dty;
    } exp_t;

    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;

    // Reference model: plain arrays following the register-bank rules.
    logic [15:0] m_shadow [4];
    logic [15:0] m_active [4];
    logic [3:0]  m_dirty;

    task automatic model_reset();
        for (int r = 0; r < 4; r++) begin
            m_shadow[r] = 16'h0000;
            m_active[r] = 16'h0000;
        end
        m_dirty = 4'b0000;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: rd_data is presented every cycle; compare one queued item per cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("rd_data", rd_data, e.rd);
            check("dirty", {12'h0, dirty}, {12'h0, e.dty});
            check("pending", {15'h0, pending}, {15'h0, |e.dty});
`ifdef BYTE_PARITY_EN
            check("rd_par", {14'h0, rd_par}, {14'h0, ^e.rd[15:8], ^e.rd[7:0]});
`endif
        end
    end

    // One clock of stimulus; the expected post-edge response is queued.
    task automatic cyc(input logic we, input logic [1:0] wa, input logic [1:0] be,
                       input logic [15:0] d, input logic cm, input logic [1:0] ra);
        exp_t e;
        bit   eff;
        @(negedge clk); #1;
        wr_en = we; wr_addr = wa; byteena = be; D = d; commit = cm; rd_addr = ra;
        e.rd = m_active[ra];
        eff  = we && (be != 2'b00);
        if (cm) begin
            for (int r = 0; r < 4; r++) m_active[r] = m_shadow[r];
            m_dirty = 4'b0000;
        end
        if (eff) begin
            if (be[0]) m_shadow[wa][7:0]  = d[7:0];
            if (be[1]) m_shadow[wa][15:8] = d[15:8];
            m_dirty[wa] = 1'b1;
        end
        e.dty = m_dirty;
        q.push_back(e);
    endtask

    task automatic idle(input logic [1:0] ra);
        cyc(1'b0, 2'd0, 2'b00, 16'h0, 1'b0, ra);
    endtask

    initial begin
        model_reset();
        #2;
        check("reset rd_data", rd_data, 16'h0000);
        check("reset dirty", {12'h0, dirty}, 16'h0000);
        check("reset pending", {15'h0, pending}, 16'h0000);
        @(negedge clk); #1 resetn = 1'b1;

        for (int a = 0; a < 4; a++) idle(2'(a));

        // Staging then commit
        cyc(1'b1, 2'd1, 2'b11, 16'hAAAA, 1'b0, 2'd1);
        idle(2'd1);
        cyc(1'b0, 2'd0, 2'b00, 16'h0, 1'b1, 2'd1);
        idle(2'd1);
        // Byte enables
        cyc(1'b1, 2'd1, 2'b10, 16'hCCCC, 1'b0, 2'd1);
        cyc(1'b0, 2'd0, 2'b00, 16'h0, 1'b1, 2'd1);
        idle(2'd1);
        cyc(1'b1, 2'd1, 2'b01, 16'hF0F0, 1'b0, 2'd1);
        cyc(1'b0, 2'd0, 2'b00, 16'h0, 1'b1, 2'd1);
        idle(2'd1);
        cyc(1'b1, 2'd1, 2'b00, 16'h5555, 1'b0, 2'd1);
        idle(2'd1);
        // Write colliding with commit
        cyc(1'b1, 2'd2, 2'b11, 16'h1234, 1'b1, 2'd2);
        idle(2'd2);
        cyc(1'b0, 2'd0, 2'b00, 16'h0, 1'b1, 2'd2);
        idle(2'd2);
        // Parity pattern
        cyc(1'b1, 2'd3, 2'b11, 16'h0100, 1'b1, 2'd3);
        cyc(1'b0, 2'd0, 2'b00, 16'h0, 1'b1, 2'd3);
        idle(2'd3);
        idle(2'd3);

        // Reset mid-operation with dirty=0110 and rd_data=CCF0
        cyc(1'b1, 2'd1, 2'b11, 16'h1111, 1'b0, 2'd1);
        cyc(1'b1, 2'd2, 2'b01, 16'h2222, 1'b0, 2'd1);
        idle(2'd1);
        @(negedge clk); #1;
        check("pre-reset rd_data", rd_data, 16'hCCF0);
        check("pre-reset dirty", {12'h0, dirty}, 16'h0006);
        #2 resetn = 1'b0;
        #1;
        check("async rd_data", rd_data, 16'h0000);
        check("async dirty", {12'h0, dirty}, 16'h0000);
        check("async pending", {15'h0, pending}, 16'h0000);
        q.delete();
        model_reset();
        @(negedge clk); #1 resetn = 1'b1;
        for (int a = 0; a < 4; a++) idle(2'(a));
        cyc(1'b0, 2'd0, 2'b00, 16'h0, 1'b1, 2'd0);
        for (int a = 0; a < 4; a++) idle(2'(a));

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            cyc(1'($urandom), 2'($urandom), 2'($urandom), 16'($urandom),
                ($urandom_range(0, 3) == 0), 2'($urandom));
        end
        idle(2'd0);

        // Bounded drain of the scoreboard
        for (int k = 0; k < 4 && q.size() > 0; k++) @(negedge clk);
        #1;
        check("queue drained", 16'(q.size()), 16'h0000);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
